// File: rtl/caliptra_fpga_jtag_pkg.sv
// rtl/caliptra_fpga_jtag_pkg.sv - shared types and constants for the JTAG shift engine
// FSM state type, command sizing and the jtag_in bus bit positions.
package caliptra_fpga_jtag_pkg;

  localparam int JTAG_MAX_BITS = 32;
  localparam int JTAG_LEN_W    = 6;

  localparam int JTAG_IN_TCK    = 0;
  localparam int JTAG_IN_TDI    = 1;
  localparam int JTAG_IN_TMS    = 2;
  localparam int JTAG_IN_TRST_N = 3;
  localparam int JTAG_IN_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } jtag_state_e;

  // Packs the engine pins into the core's jtag_in ordering.
  function automatic logic [JTAG_IN_W-1:0] jtag_in_pack(input logic tck, input logic tdi,
                                                        input logic tms, input logic trst_n);
    logic [JTAG_IN_W-1:0] v;
    v                 = '0;
    v[JTAG_IN_TCK]    = tck;
    v[JTAG_IN_TDI]    = tdi;
    v[JTAG_IN_TMS]    = tms;
    v[JTAG_IN_TRST_N] = trst_n;
    return v;
  endfunction

  function automatic logic [JTAG_LEN_W-1:0] jtag_clamp_len(input logic [JTAG_LEN_W-1:0] len);
    return (len > JTAG_LEN_W'(JTAG_MAX_BITS)) ? JTAG_LEN_W'(JTAG_MAX_BITS) : len;
  endfunction

endpackage

// File: rtl/jtag_tck_divider.sv
// rtl/jtag_tck_divider.sv - TCK half-period counter
// Counts CLK_DIV core cycles per half-period while enabled; phase_end_o marks the last one.
module jtag_tck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic phase_end_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/jtag_shift_engine.sv
// rtl/jtag_shift_engine.sv - register-driven JTAG bit-bang shifter
// Optional CPTRA_FPGA_JTAG_LOOPBACK_EN samples TDO from the driven TDI for self-test.
module jtag_shift_engine
  import caliptra_fpga_jtag_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = JTAG_MAX_BITS
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [JTAG_LEN_W-1:0] cmd_len,
  input  logic [MAX_BITS-1:0]   cmd_tms,
  input  logic [MAX_BITS-1:0]   cmd_tdi,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MAX_BITS-1:0]   rsp_tdo,
  input  logic                  trst_req,
  output logic                  jtag_tck,
  output logic                  jtag_tdi,
  output logic                  jtag_tms,
  output logic                  jtag_trst_n,
  input  logic                  jtag_tdo
);

  localparam int IDX_W = $clog2(MAX_BITS);

  jtag_state_e           state_q, state_d;
  logic [JTAG_LEN_W-1:0] len_q, len_d;
  logic [JTAG_LEN_W-1:0] idx_q, idx_d;
  logic [JTAG_LEN_W-1:0] nxt_idx;
  logic [JTAG_LEN_W-1:0] clamped_len;
  logic [MAX_BITS-1:0]   tms_sh_q, tms_sh_d;
  logic [MAX_BITS-1:0]   tdi_sh_q, tdi_sh_d;
  logic [MAX_BITS-1:0]   rsp_tdo_q, rsp_tdo_d;
  logic                  tck_q, tck_d;
  logic                  tms_q, tms_d;
  logic                  tdi_q, tdi_d;
  logic                  trst_n_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  empty_q, empty_d;
  logic                  div_en;
  logic                  phase_end;
  logic                  tdo_src;

  assign div_en = (state_q == LOW) || (state_q == HIGH);

  jtag_tck_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk_i      (core_clk),
    .rst_i      (core_rst),
    .en_i       (div_en),
    .phase_end_o(phase_end)
  );

`ifdef CPTRA_FPGA_JTAG_LOOPBACK_EN
  assign tdo_src = tdi_q;
`else
  assign tdo_src = jtag_tdo;
`endif

  assign clamped_len = jtag_clamp_len(cmd_len);
  assign nxt_idx     = idx_q + JTAG_LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tms_sh_d    = tms_sh_q;
    tdi_sh_d    = tdi_sh_q;
    rsp_tdo_d   = rsp_tdo_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    empty_d     = empty_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A zero-length command spends one extra cycle here so it reaches DONE a cycle later.
        if (empty_q) begin
          empty_d = 1'b0;
          state_d = DONE;
        end else if (cmd_valid && cmd_ready_q) begin
          tms_sh_d  = cmd_tms;
          tdi_sh_d  = cmd_tdi;
          len_d     = clamped_len;
          idx_d     = '0;
          rsp_tdo_d = '0;
          if (clamped_len == '0) begin
            empty_d = 1'b1;
          end else begin
            tms_d   = cmd_tms[0];
            tdi_d   = cmd_tdi[0];
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          tck_d                       = 1'b1;
          rsp_tdo_d[idx_q[IDX_W-1:0]] = tdo_src;
          state_d                     = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          tck_d = 1'b0;
          idx_d = nxt_idx;
          if (nxt_idx == len_q) begin
            state_d = DONE;
          end else begin
            tms_d   = tms_sh_q[nxt_idx[IDX_W-1:0]];
            tdi_d   = tdi_sh_q[nxt_idx[IDX_W-1:0]];
            state_d = LOW;
          end
        end
      end
      DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE) && !empty_d;
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      tms_sh_q    <= '0;
      tdi_sh_q    <= '0;
      rsp_tdo_q   <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tms_sh_q    <= tms_sh_d;
      tdi_sh_q    <= tdi_sh_d;
      rsp_tdo_q   <= rsp_tdo_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      empty_q     <= empty_d;
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      trst_n_q <= 1'b0;
    end else begin
      trst_n_q <= ~trst_req;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tdo     = rsp_tdo_q;
  assign jtag_tck    = tck_q;
  assign jtag_tdi    = tdi_q;
  assign jtag_tms    = tms_q;
  assign jtag_trst_n = trst_n_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb/tb_jtag_shift_engine.sv - directed table-driven bench for jtag_shift_engine
module tb_jtag_shift_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        trst_req;
  logic        jtag_tck;
  logic        jtag_tdi;
  logic        jtag_tms;
  logic        jtag_trst_n;
  logic        jtag_tdo;

  int checks   = 0;
  int failures = 0;

  jtag_shift_engine #(
    .CLK_DIV (4),
    .MAX_BITS(32)
  ) dut (
    .core_clk   (clk),
    .core_rst   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_tms    (cmd_tms),
    .cmd_tdi    (cmd_tdi),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_tdo    (rsp_tdo),
    .trst_req   (trst_req),
    .jtag_tck   (jtag_tck),
    .jtag_tdi   (jtag_tdi),
    .jtag_tms   (jtag_tms),
    .jtag_trst_n(jtag_trst_n),
    .jtag_tdo   (jtag_tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TDO target model: presents pattern bit k after the k-th TCK falling edge of a command.
  int          rise_cnt  = 0;
  int          fall_cnt  = 0;
  int          tdo_base  = 0;
  logic [31:0] tdo_pat   = '0;
  longint      rise_t   [256];
  logic        rise_tms [256];
  logic        rise_tdi [256];

  assign jtag_tdo = tdo_pat[(fall_cnt - tdo_base) & 31];

  always @(posedge jtag_tck) begin
    rise_t[rise_cnt & 255]   <= $time;
    rise_tms[rise_cnt & 255] <= jtag_tms;
    rise_tdi[rise_cnt & 255] <= jtag_tdi;
    rise_cnt                 <= rise_cnt + 1;
  end

  always @(negedge jtag_tck) fall_cnt <= fall_cnt + 1;

  typedef struct {
    logic [5:0]  len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic [31:0] pat;
    logic [31:0] exp_tdo;
    int          exp_lat;
    int          exp_pulses;
    int          hold;
    int          trst_at;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << n) - 32'h1;
  endfunction

  task automatic run_cmd(input vec_t v, output int lat, output logic [31:0] tdo,
                         output int pulses, output logic [31:0] tms_bits,
                         output logic [31:0] tdi_bits, output int first_off,
                         output bit period_ok, output bit stable, output bit trst_ok,
                         output bit done_ok);
    int          base;
    int          n;
    longint      t_acc;
    bit          seen;
    logic [31:0] snap;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    tdo_pat   = v.pat;
    tdo_base  = fall_cnt;
    base      = rise_cnt;
    cmd_len   = v.len;
    cmd_tms   = v.tms;
    cmd_tdi   = v.tdi;
    cmd_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    cmd_valid = 1'b0;
    lat     = 0;
    seen    = 1'b0;
    trst_ok = 1'b1;
    while (!seen && lat < 400) begin
      @(posedge clk); #1; lat++;
      if (v.trst_at > 0 && lat == v.trst_at) trst_req = 1'b1;
      if (v.trst_at > 0 && lat == v.trst_at + 1) begin
        trst_ok  = (jtag_trst_n == 1'b0);
        trst_req = 1'b0;
      end
      seen = rsp_valid;
    end
    if (!seen) lat = -1;
    pulses    = rise_cnt - base;
    tms_bits  = '0;
    tdi_bits  = '0;
    period_ok = 1'b1;
    for (int i = 0; i < pulses && i < 32; i++) begin
      tms_bits[i] = rise_tms[(base + i) & 255];
      tdi_bits[i] = rise_tdi[(base + i) & 255];
      if (i > 0 && (rise_t[(base + i) & 255] - rise_t[(base + i - 1) & 255]) != 80)
        period_ok = 1'b0;
    end
    first_off = (pulses > 0) ? int'((rise_t[base & 255] - t_acc) / 10) : -1;
    snap   = rsp_tdo;
    stable = 1'b1;
    repeat (v.hold) begin
      @(posedge clk); #1;
      if (rsp_tdo !== snap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) stable = 1'b0;
    end
    tdo       = snap;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    done_ok   = (rsp_valid == 1'b0) && (cmd_ready == 1'b1) && (jtag_tck == 1'b0);
  endtask

  initial begin
    int          lat;
    logic [31:0] tdo;
    int          pulses;
    logic [31:0] tms_bits;
    logic [31:0] tdi_bits;
    int          first_off;
    bit          period_ok;
    bit          stable;
    bit          trst_ok;
    bit          done_ok;
    logic [31:0] exp_tdo;
    int          base;
    int          n;
    bit          rv;

    vecs[0] = '{6'd5,  32'h0000_001F, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 41,  5,  0,  0};
    vecs[1] = '{6'd8,  32'h0000_0000, 32'h0000_00A5, 32'h0000_003C, 32'h0000_003C, 65,  8,  0,  0};
    vecs[2] = '{6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2,   0,  0,  0};
    vecs[3] = '{6'd40, 32'hFFFF_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 257, 32, 0,  0};
    vecs[4] = '{6'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 9,   1,  0,  0};
    vecs[5] = '{6'd16, 32'h0000_0000, 32'h0000_BEEF, 32'h0000_1234, 32'h0000_1234, 129, 16, 10, 0};
    vecs[6] = '{6'd12, 32'h0000_0AAA, 32'h0000_0F0F, 32'hF000_0FC3, 32'h0000_0FC3, 97,  12, 0,  30};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_tms   = '0;
    cmd_tdi   = '0;
    rsp_ready = 1'b0;
    trst_req  = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_tck", {31'd0, jtag_tck}, 32'd0);
    chk("rst_tms", {31'd0, jtag_tms}, 32'd1);
    chk("rst_tdi", {31'd0, jtag_tdi}, 32'd0);
    chk("rst_trst_n", {31'd0, jtag_trst_n}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_tdo", rsp_tdo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_trst_n", {31'd0, jtag_trst_n}, 32'd1);
    chk("post_rst_tck", {31'd0, jtag_tck}, 32'd0);
    chk("post_rst_tms", {31'd0, jtag_tms}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], lat, tdo, pulses, tms_bits, tdi_bits, first_off, period_ok, stable,
              trst_ok, done_ok);
`ifdef CPTRA_FPGA_JTAG_LOOPBACK_EN
      exp_tdo = vecs[i].tdi & msk(vecs[i].exp_pulses);
`else
      exp_tdo = vecs[i].exp_tdo;
`endif
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_rsp_tdo", i), tdo, exp_tdo);
      chk($sformatf("v%0d_tck_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("v%0d_tms_bits", i), tms_bits, vecs[i].tms & msk(vecs[i].exp_pulses));
      chk($sformatf("v%0d_tdi_bits", i), tdi_bits, vecs[i].tdi & msk(vecs[i].exp_pulses));
      chk($sformatf("v%0d_done_handshake", i), {31'd0, done_ok}, 32'd1);
      if (vecs[i].exp_pulses > 0) begin
        chk($sformatf("v%0d_first_rise_cycles", i), first_off, 4);
        chk($sformatf("v%0d_tck_period", i), {31'd0, period_ok}, 32'd1);
      end
      if (vecs[i].hold > 0) chk($sformatf("v%0d_hold_stable", i), {31'd0, stable}, 32'd1);
      if (vecs[i].trst_at > 0) chk($sformatf("v%0d_trst_follow", i), {31'd0, trst_ok}, 32'd1);
    end

    // Reset asserted while bit 3 is being clocked aborts the command with no response.
    tdo_pat   = '0;
    tdo_base  = fall_cnt;
    base      = rise_cnt;
    cmd_len   = 6'd8;
    cmd_tms   = 32'h0000_00FF;
    cmd_tdi   = 32'h0000_00FF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while ((rise_cnt - base) < 4 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_reach_bit3", rise_cnt - base, 32'd4);
    chk("abort_tck_before", {31'd0, jtag_tck}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tck", {31'd0, jtag_tck}, 32'd0);
    chk("abort_tms", {31'd0, jtag_tms}, 32'd1);
    chk("abort_tdi", {31'd0, jtag_tdi}, 32'd0);
    chk("abort_trst_n", {31'd0, jtag_trst_n}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_rsp_tdo", rsp_tdo, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rv  = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rsp_valid) rv = 1'b1;
    end
    chk("abort_no_rsp", {31'd0, rv}, 32'd0);
    chk("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_idle_tck", {31'd0, jtag_tck}, 32'd0);

    run_cmd(vecs[1], lat, tdo, pulses, tms_bits, tdi_bits, first_off, period_ok, stable,
            trst_ok, done_ok);
`ifdef CPTRA_FPGA_JTAG_LOOPBACK_EN
    exp_tdo = 32'h0000_00A5;
`else
    exp_tdo = 32'h0000_003C;
`endif
    chk("after_abort_latency", lat, 32'd65);
    chk("after_abort_rsp_tdo", tdo, exp_tdo);
    chk("after_abort_pulses", pulses, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_shift_engine.md
Name: jtag_shift_engine

Overview:
- Register-driven JTAG bit-bang shifter in the FPGA wrapper fabric.
- Sits directly upstream of the Caliptra core JTAG pins. Its outputs drive the packed jtag_in bus as {trst_n, tms, tdi, tck}. Its jtag_tdo input is fed from the core's TDO return.
- The host (realtime-register AXI block) posts shift commands of up to 32 TMS/TDI bits and reads back the captured TDO bits. This allows debug without an external probe.

Parameters:
- CLK_DIV, 4, core_clk cycles per TCK half-period; legal range 1..255.
- MAX_BITS, 32, maximum bits per command; fixed at 32, the data vector width.

Ports:
- core_clk  in  1  block clock.
- core_rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  engine can accept a command.
- cmd_len  in  6  number of bits to shift, 0..32.
- cmd_tms  in  32  TMS bits, LSB shifted first.
- cmd_tdi  in  32  TDI bits, LSB shifted first.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_tdo  out  32  captured TDO bits, bit i = TDO sampled on the i-th TCK rising edge.
- trst_req  in  1  level request to assert TRST.
- jtag_tck  out  1  to jtag_in[0].
- jtag_tdi  out  1  to jtag_in[1].
- jtag_tms  out  1  to jtag_in[2].
- jtag_trst_n  out  1  to jtag_in[3].
- jtag_tdo  in  1  from the core TDO.

Behaviour:
- Reset values (all outputs registered): jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trst_n=0, cmd_ready=0, rsp_valid=0, rsp_tdo=0, FSM=IDLE. Reset mid-shift aborts the command immediately; no response is produced.
- jtag_trst_n is ~trst_req, registered by one flop. It is independent of the FSM.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
    - latch tms/tdi and len; clamp len>32 to 32;
    - clear bit index and rsp_tdo;
    - len==0: go to DONE next cycle with rsp_tdo=0;
    - otherwise go to LOW, driving jtag_tms/jtag_tdi = bit 0 on the same edge.
  - LOW: jtag_tck=0 for CLK_DIV cycles. On the last cycle, set jtag_tck=1, sample jtag_tdo into rsp_tdo[idx], then go to HIGH.
  - HIGH: jtag_tck=1 for CLK_DIV cycles. On the last cycle, set jtag_tck=0 and increment idx.
    - If idx+1==len: go to DONE. tms/tdi hold their last bit.
    - Otherwise: drive tms/tdi = bit idx+1 and go to LOW.
  - DONE: rsp_valid=1 and rsp_tdo stable until rsp_valid&&rsp_ready, then go to IDLE. cmd_ready=0 in DONE.
- TCK timing: period = 2*CLK_DIV core_clk cycles, 50% duty. TDI/TMS change only with the TCK falling edge (or at command start), giving a full half-period of setup.
- Latency: a command of N>0 bits takes 1 + 2*N*CLK_DIV cycles from acceptance to rsp_valid.
- Between commands TCK idles low; tms/tdi hold their last value.
- cmd inputs are ignored outside IDLE.
- trst_req toggling mid-shift does not disturb the shift.
- Divider counter width is 8 bits. It wraps to 0 at CLK_DIV-1.

Optional Feature:
- Macro CPTRA_FPGA_JTAG_LOOPBACK_EN.
- Defined: the TDO sample source is the registered jtag_tdi instead of the jtag_tdo port, so rsp_tdo equals cmd_tdi masked to len bits. This is a bring-up self-test; the jtag_tdo port is left unused.
- Undefined: TDO is sampled from the jtag_tdo port.

Decomposition:
- Shared package caliptra_fpga_jtag_pkg holds:
  - typedef for the FSM state enum (IDLE, LOW, HIGH, DONE);
  - localparam JTAG_MAX_BITS=32;
  - localparam JTAG_LEN_W=6;
  - constants for the jtag_in bit positions (TCK=0, TDI=1, TMS=2, TRST_N=3).
- One natural sub-module, jtag_tck_divider: the half-period counter that produces a phase_end strobe. The FSM stays in the top module.

Test Plan:
- Reset held for 5 cycles, then released → tck=0, tms=1, trst_n=0, cmd_ready=1 one cycle after release.
- CLK_DIV=4, len=5, tms=0x1F, tdi=0 → five TCK pulses of 8-cycle period with tms=1; rsp_valid at cycle 41 after acceptance.
- len=8, tdi=0xA5, jtag_tdo driven by a model shifting 0x3C on falling edges → rsp_tdo=0x0000003C.
- len=0 → rsp_valid 2 cycles after acceptance, rsp_tdo=0, no TCK edge; len=40 → exactly 32 TCK pulses.
- Reset asserted mid-shift at bit 3 → outputs return to reset values asynchronously, rsp_valid never rises; next command runs normally.
- rsp_ready held low for 10 cycles → rsp_tdo stable and cmd_ready=0 throughout. With CPTRA_FPGA_JTAG_LOOPBACK_EN defined, len=16, tdi=0xBEEF → rsp_tdo=0x0000BEEF.
